fsqrt_share_ctrl: RTL and testbench
===================================

Name: fsqrt_share_ctrl

Overview:
- Scheduler that shares one multi-cycle Newton-iteration float square-root unit between NREQ requesters, e.g. two issue ports of the FPU.
- Arbitrates round-robin, latches the winner's operand and rounding mode, and pulses the unit's start.
- Waits for the unit's busy to fall, captures the result, and returns it to the owning requester with a valid/ready handshake.
- A watchdog flags a hung unit.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TIMEOUT, 64, maximum WAIT cycles before abort.
- CW, 7, timeout counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset; asynchronous, active-high.
- ena  in  1  global enable; 0 freezes all state, counters and outputs.
- req  in  NREQ  request level, per requester.
- req_d  in  NREQ*32  packed operands; requester i occupies bits [32i+31:32i].
- req_rm  in  NREQ*2  packed rounding modes.
- req_ack  out  NREQ  one-hot, one-cycle pulse: request accepted.
- rsp_valid  out  NREQ  one-hot; held until the matching rsp_ready.
- rsp_ready  in  NREQ  response accept, per requester.
- rsp_s  out  32  result; valid while any rsp_valid bit is 1.
- u_d  out  32  operand to the unit.
- u_rm  out  2  rounding mode to the unit.
- u_start  out  1  start strobe to the unit.
- u_busy  in  1  unit busy.
- u_s  in  32  unit result.
- owner  out  log2(NREQ) (minimum 1)  index of the current owner.
- busy  out  1  controller not in IDLE.
- timeout  out  1  sticky watchdog error.

Behaviour:
- Reset (clr=1, asynchronous): state IDLE; all outputs 0; RR pointer 0; timeout 0; seen_busy 0; counter 0.
- All state updates below occur only on edges with ena=1. With ena=0 everything holds, including u_start. The unit shares the same ena, so a held u_start is consistent with the unit's own freeze.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is 1, the round-robin grant picks the first set bit at or after ptr+1 (mod NREQ).
  - On that edge: latch u_d/u_rm from the winner, set owner, assert req_ack[owner] for exactly one cycle, go to ISSUE.
  - No req set: stay in IDLE.
- ISSUE: u_start=1 for exactly this one cycle; clear seen_busy and counter; go to WAIT.
- WAIT:
  - Counter increments every enabled cycle.
  - u_busy=1 sets seen_busy.
  - Edge with seen_busy=1 and u_busy=0: capture u_s into rsp_s, set rsp_valid[owner], go to RESP.
  - Counter reaching TIMEOUT before completion: rsp_s=32'h7FC00000 (qNaN), set timeout (sticky until clr), set rsp_valid[owner], go to RESP.
  - If u_busy never rises, the watchdog covers it.
- RESP:
  - Hold rsp_valid and rsp_s until rsp_ready[owner]=1.
  - On that edge: clear rsp_valid, set ptr=owner, go to IDLE.
  - rsp_ready bits of non-owners are ignored.
- Latency: req seen in IDLE → ack at +1 edge → u_start during the next cycle → response one edge after busy falls.
- Back-to-back gap: at least one IDLE cycle between RESP exit and the next ack.
- busy=1 in every state except IDLE.
- Requester rules:
  - A requester must drop req in the cycle after its ack. Req still high in IDLE is treated as a new request.
  - Req dropped before ack is never served.
  - Simultaneous requests are resolved by RR only; there is no starvation under continuous requests.
- Operands are latched at ack. Later changes to req_d do not affect the current operation.
- clr during WAIT returns the controller to IDLE immediately with no response. The unit is reset by the same clr.

Decomposition:
- Package fp_share_pkg:
  - state enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - QNAN=32'h7FC00000;
  - rounding-mode encodings (RNE=0, RZ=1, RD=2, RU=3).
- Sub-module rr_arbiter:
  - inputs: req[NREQ], ptr;
  - outputs: one-hot grant, index;
  - purely combinational.
- The FSM and watchdog stay in fsqrt_share_ctrl.

Test Plan:
- Single request, req[0]=1, req_d0=32'h41100000, rm=0, behavioural unit with 20-cycle busy → ack[0] one pulse; u_start one cycle; rsp_valid[0] with rsp_s=32'h40400000; busy drops after rsp_ready[0].
- Simultaneous req=2'b11 from reset, d0=32'h41100000, d1=32'h00003200 → requester 1 served first (ptr=0), then requester 0; exactly one ack per operation; u_d matches the owner each time.
- Continuous req=2'b11 for 4 operations → grants alternate 1,0,1,0.
- Unit model never raises busy → after TIMEOUT=64 WAIT cycles: rsp_s=32'h7FC00000, timeout=1 and stays 1 through the next normal operation until clr.
- rsp_ready held 0 for 10 cycles → rsp_valid and rsp_s stable; a new req on the other port gets no ack until RESP exits.
- ena=0 for 5 cycles mid-WAIT → counter and state frozen, response delayed by 5 cycles. Separately, clr=1 mid-WAIT → all outputs 0 asynchronously, no rsp_valid.

Source files
------------

// File: rtl/fp_share_pkg.sv
// Shared types and constants for the square-root sharing controller.
package fp_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0,
    RM_RZ  = 2'd1,
    RM_RD  = 2'd2,
    RM_RU  = 2'd3
  } rm_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr+1 (mod NREQ).
module rr_arbiter
  import fp_share_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int OW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [OW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [OW-1:0]   index_o
);

  logic [OW-1:0] idx_s;
  logic [OW-1:0] cand_s;
  logic          any_s;

  // Scan from the farthest candidate back to ptr+1 so the nearest set bit wins.
  always_comb begin
    idx_s  = '0;
    cand_s = '0;
    any_s  = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      cand_s = OW'((int'(ptr_i) + k) % NREQ);
      idx_s  = req_i[cand_s] ? cand_s : idx_s;
      any_s  = any_s | req_i[cand_s];
    end
  end

  assign grant_o = any_s ? (NREQ'(1) << idx_s) : '0;
  assign index_o = idx_s;

endmodule

// File: rtl/fsqrt_share_ctrl.sv
// Shares one multi-cycle square-root unit between NREQ requesters with
// round-robin issue, valid/ready response return and a sticky watchdog.
module fsqrt_share_ctrl
  import fp_share_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = 64,
  parameter  int CW      = 7,
  localparam int OW      = idx_w(NREQ)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ena,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_d,
  input  logic [NREQ*2-1:0] req_rm,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_s,
  output logic [31:0]       u_d,
  output logic [1:0]        u_rm,
  output logic              u_start,
  input  logic              u_busy,
  input  logic [31:0]       u_s,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic              timeout
);

  state_e          state_q;
  logic [OW-1:0]   ptr_q;
  logic [OW-1:0]   owner_q;
  logic [NREQ-1:0] own_oh_q;
  logic [NREQ-1:0] ack_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [31:0]     rsp_s_q;
  logic [31:0]     u_d_q;
  logic [1:0]      u_rm_q;
  logic            u_start_q;
  logic            seen_q;
  logic [CW-1:0]   cnt_q;
  logic            to_q;

  logic [NREQ-1:0] grant_s;
  logic [OW-1:0]   gidx_s;
  logic [31:0]     sel_d_s;
  logic [1:0]      sel_rm_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (grant_s),
    .index_o (gidx_s)
  );

  // AND-OR select of the winner's operand and rounding mode.
  always_comb begin
    sel_d_s  = 32'h0000_0000;
    sel_rm_s = 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      sel_d_s  = sel_d_s  | (req_d[32*i +: 32] & {32{grant_s[i]}});
      sel_rm_s = sel_rm_s | (req_rm[2*i +: 2]  & {2{grant_s[i]}});
    end
  end

  // Controller FSM and watchdog; ena=0 freezes every register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      own_oh_q    <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      rsp_s_q     <= 32'h0000_0000;
      u_d_q       <= 32'h0000_0000;
      u_rm_q      <= 2'b00;
      u_start_q   <= 1'b0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (grant_s != '0) begin
            owner_q   <= gidx_s;
            own_oh_q  <= grant_s;
            ack_q     <= grant_s;
            u_d_q     <= sel_d_s;
            u_rm_q    <= sel_rm_s;
            u_start_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end else begin
            ack_q <= '0;
          end
        end
        ST_ISSUE: begin
          ack_q     <= '0;
          u_start_q <= 1'b0;
          seen_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (u_busy) begin
            seen_q <= 1'b1;
          end else begin
            seen_q <= seen_q;
          end
          // Normal completion wins over a watchdog expiring on the same edge.
          if (seen_q && !u_busy) begin
            rsp_s_q     <= u_s;
            rsp_valid_q <= own_oh_q;
            state_q     <= ST_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_s_q     <= QNAN;
            to_q        <= 1'b1;
            rsp_valid_q <= own_oh_q;
            state_q     <= ST_RESP;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid_q <= '0;
            ptr_q       <= owner_q;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_RESP;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack   = ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign u_d       = u_d_q;
  assign u_rm      = u_rm_q;
  assign u_start   = u_start_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign timeout   = to_q;

endmodule

// File: tb/tb_fsqrt_share_ctrl.sv
// Scoreboard bench for fsqrt_share_ctrl with a behavioural square-root unit stub.
module tb_fsqrt_share_ctrl;
  import fp_share_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 64;
  localparam int CW      = 7;
  localparam int LAT     = 20;

  logic              clk = 1'b0;
  logic              clr, ena;
  logic [NREQ-1:0]   req, req_ack, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0] req_d;
  logic [NREQ*2-1:0] req_rm;
  logic [31:0]       rsp_s, u_d, u_s;
  logic [1:0]        u_rm;
  logic              u_start, u_busy, busy, timeout;
  logic [0:0]        owner;

  fsqrt_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .clr(clr), .ena(ena), .req(req), .req_d(req_d), .req_rm(req_rm),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s),
    .u_d(u_d), .u_rm(u_rm), .u_start(u_start), .u_busy(u_busy), .u_s(u_s),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [31:0] op; logic [1:0] rm; } ack_t;
  typedef struct { int idx; logic [31:0] res; bit to; int lat; } rsp_t;
  ack_t ackq[$];
  rsp_t rspq[$];
  int   mptr = 0;
  bit   msticky = 1'b0;
  int   freeze_add = 0;
  int   ready_delay = 0;
  int   last_start = 0;
  int   last_hs = -10;

  // Behavioural unit: known square roots, otherwise an operand/rm-dependent tag.
  function automatic logic [31:0] unit_fn(input logic [31:0] op, input logic [1:0] rm);
    if (op == 32'h4110_0000) return 32'h4040_0000;
    if (op == 32'h4080_0000) return 32'h4000_0000;
    return {op[31:2] ^ 30'h2AAA_AAAA, rm};
  endfunction

  int          ucnt = 0;
  logic [31:0] uop = 32'h0;
  logic [1:0]  urm = 2'b00;
  bit          hang = 1'b0;
  always @(posedge clk or posedge clr) begin
    if (clr) ucnt <= 0;
    else if (ena) begin
      if (u_start) begin ucnt <= LAT; uop <= u_d; urm <= u_rm; end
      else if (ucnt > 0) ucnt <= ucnt - 1;
    end
  end
  assign u_busy = (ucnt > 0) && !hang;
  assign u_s    = unit_fn(uop, urm);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model order: repeatedly serve the first pending requester after the last owner.
  task automatic batch(input logic [NREQ-1:0] mask, input logic [NREQ*32-1:0] d,
                       input logic [NREQ*2-1:0] rm, input bit to_op, input bit no_rsp);
    logic [NREQ-1:0] pend;
    int p, n;
    ack_t a;
    rsp_t e;
    pend = mask;
    while (pend != '0) begin
      p = -1;
      for (int k = 1; k <= NREQ; k++)
        if (p < 0 && pend[(mptr + k) % NREQ]) p = (mptr + k) % NREQ;
      a.idx = p; a.op = d[32*p +: 32]; a.rm = rm[2*p +: 2];
      ackq.push_back(a);
      if (!no_rsp) begin
        msticky = msticky | to_op;
        e.idx = p;
        e.res = to_op ? QNAN : unit_fn(a.op, a.rm);
        e.to  = msticky;
        e.lat = to_op ? TIMEOUT + 1 : LAT + 2 + freeze_add;
        rspq.push_back(e);
      end
      mptr = p;
      pend[p] = 1'b0;
    end
    req_d  = d;
    req_rm = rm;
    req    = req | mask;
    n = 0;
    while ((req & mask) != '0 && n < 2000) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NREQ; i++)
        if (req[i] && req_ack[i]) req[i] = 1'b0;
    end
    if ((req & mask) != '0) begin
      chk("ack_wait_expired", 32'(req & mask), 32'h0);
      req = '0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while ((ackq.size() != 0 || rspq.size() != 0 || busy !== 1'b0 || rsp_valid != '0) && n < 1000);
    if (n >= 1000) chk("drain_expired", 32'(busy), 32'h0);
  endtask

  // Monitor: responses first (handshake bookkeeping), then acks, every falling edge.
  initial begin : monitor
    bit act, granted, stab, prev_ack;
    int w;
    logic [31:0]     hs;
    logic [NREQ-1:0] hv;
    ack_t a;
    rsp_t e;
    act = 1'b0; granted = 1'b0; stab = 1'b1; prev_ack = 1'b0; w = 0;
    hs = 32'h0; hv = '0;
    rsp_ready = '0;
    forever begin
      @(negedge clk);
      if (clr) begin
        act = 1'b0; granted = 1'b0; prev_ack = 1'b0; rsp_ready = '0;
      end else begin
        if (act && granted) begin
          chk("rsp_clear", 32'(rsp_valid), 32'h0);
          chk("rsp_stable", 32'(stab), 32'h1);
          act = 1'b0; granted = 1'b0; rsp_ready = '0; last_hs = cyc;
        end else if (act) begin
          if (rsp_valid !== hv || rsp_s !== hs) stab = 1'b0;
          w++;
          if (w >= ready_delay) begin rsp_ready = hv; granted = 1'b1; end
          else rsp_ready = ~hv;
        end else if (rsp_valid != '0) begin
          act = 1'b1; w = 0; hs = rsp_s; hv = rsp_valid; stab = 1'b1;
          if (rspq.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
          else begin
            e = rspq.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
            chk("rsp_s", rsp_s, e.res);
            chk("timeout_flag", 32'(timeout), 32'(e.to));
            chk("rsp_latency", 32'(cyc - last_start), 32'(e.lat));
          end
          if (ready_delay == 0) begin rsp_ready = hv; granted = 1'b1; end
          else rsp_ready = ~hv;
        end
        if (prev_ack) chk("ack_pulse", {29'h0, req_ack, u_start}, 32'h0);
        prev_ack = 1'b0;
        if (req_ack != '0) begin
          prev_ack = 1'b1;
          if (ackq.size() == 0) chk("unexpected_ack", 32'(req_ack), 32'h0);
          else begin
            a = ackq.pop_front();
            chk("req_ack", 32'(req_ack), 32'(1 << a.idx));
            chk("owner", 32'(owner), 32'(a.idx));
            chk("u_d", u_d, a.op);
            chk("u_rm", 32'(u_rm), 32'(a.rm));
            chk("u_start", 32'(u_start), 32'h1);
            chk("busy_issue", 32'(busy), 32'h1);
            chk("ack_gap", 32'(cyc - last_hs >= 1), 32'h1);
          end
          last_start = cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    errors++;
    checks++;
    $display("FAIL global_time_limit: actual=expired required=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stim
    clr = 1'b1; ena = 1'b1; req = '0; req_d = '0; req_rm = '0;
    #1;
    chk("rst_req_ack", 32'(req_ack), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_s", rsp_s, 32'h0);
    chk("rst_u_d", u_d, 32'h0);
    chk("rst_u_start", 32'(u_start), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Single request on port 0: sqrt(9.0) = 3.0
    batch(2'b01, {32'h0, 32'h4110_0000}, 4'b0000, 1'b0, 1'b0);
    drain();
    chk("busy_after_ready", 32'(busy), 32'h0);

    // Simultaneous requests: port 1 first, then port 0; then continuous alternation
    batch(2'b11, {32'h0000_3200, 32'h4110_0000}, 4'b1000, 1'b0, 1'b0);
    batch(2'b11, {32'h4080_0000, 32'h1234_5678}, 4'b0110, 1'b0, 1'b0);
    batch(2'b11, {32'hCAFE_0001, 32'h4110_0000}, 4'b1101, 1'b0, 1'b0);
    drain();

    // Hung unit: watchdog answers qNaN, then the flag stays through a normal op
    hang = 1'b1;
    batch(2'b10, {32'h4080_0000, 32'h0}, 4'b0000, 1'b1, 1'b0);
    drain();
    hang = 1'b0;
    batch(2'b01, {32'h0, 32'h4110_0000}, 4'b0000, 1'b0, 1'b0);
    drain();

    // Slow rsp_ready while the other port requests during RESP
    ready_delay = 10;
    batch(2'b01, {32'h0, 32'h4080_0000}, 4'b0001, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (rsp_valid == '0 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) chk("rsp_wait_expired", 32'(rsp_valid), 32'h1);
    end
    batch(2'b10, {32'h3F80_0000, 32'h0}, 4'b1100, 1'b0, 1'b0);
    drain();
    ready_delay = 0;

    // Five-cycle freeze mid-WAIT delays the response by exactly five cycles
    freeze_add = 5;
    batch(2'b01, {32'h0, 32'h4110_0000}, 4'b0010, 1'b0, 1'b0);
    freeze_add = 0;
    repeat (8) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    chk("freeze_busy", 32'(busy), 32'h1);
    chk("freeze_valid", 32'(rsp_valid), 32'h0);
    ena = 1'b1;
    drain();

    // Randomized batches
    for (int it = 0; it < 12; it++) begin
      ready_delay = $urandom_range(0, 3);
      batch(NREQ'($urandom_range(1, 3)), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
            1'b0, 1'b0);
    end
    drain();
    ready_delay = 0;

    // Asynchronous clear mid-WAIT: everything back to zero, no response
    batch(2'b01, {32'h0, 32'h4110_0000}, 4'b0000, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_busy", 32'(busy), 32'h0);
    chk("clr_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("clr_u_start", 32'(u_start), 32'h0);
    chk("clr_timeout", 32'(timeout), 32'h0);
    chk("clr_u_d", u_d, 32'h0);
    mptr = 0;
    msticky = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    batch(2'b11, {32'h4080_0000, 32'h4110_0000}, 4'b0000, 1'b0, 1'b0);
    drain();
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
